// File: rtl/bram_delay_line_ctrl.sv
// Purpose : circular-buffer audio delay line driving an external single-port read-first BRAM.
// Latency : output sample leaves RAM_LATENCY cycles after the write/read access, plus one FIFO cycle.
// Backpr. : credit based; s_ready_out drops when in-flight reads plus FIFO occupancy reach 4.
//
// Ports   : clk_in/rst_in_n (async active-low), delay_len_in/clear_in control,
//           s_* input stream, m_* output stream, ram_* BRAM client port.
// Option  : define DELAY_LINE_ZERO_FILL_EN to output 0 for samples read before the line is primed.

// Small generic FIFO. D must be a power of two (pointers wrap naturally).
// The caller never pushes when full nor pops when empty.
module dl_fifo #(
    parameter int W  = 16,
    parameter int D  = 4,
    parameter int PW = $clog2(D)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         push,
    input  logic [W-1:0] push_dat,
    input  logic         pop,
    output logic [W-1:0] head_dat,
    output logic [PW:0]  count
);
    logic [W-1:0]  mem [D];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    assign head_dat = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < D; i++) mem[i] <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= push_dat;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
        end
    end
endmodule

module bram_delay_line_ctrl #(
    parameter int WIDTH       = 16,
    parameter int DEPTH       = 1024,
    parameter int RAM_LATENCY = 1,      // 1 or 2 only
    parameter int AW          = $clog2(DEPTH)
) (
    input  logic             clk_in,
    input  logic             rst_in_n,
    input  logic [AW:0]      delay_len_in,
    input  logic             clear_in,
    input  logic [WIDTH-1:0] s_data_in,
    input  logic             s_valid_in,
    output logic             s_ready_out,
    output logic [WIDTH-1:0] m_data_out,
    output logic             m_valid_out,
    input  logic             m_ready_in,
    output logic [AW-1:0]    ram_addr_out,
    output logic [WIDTH-1:0] ram_din_out,
    output logic             ram_we_out,
    output logic             ram_en_out,
    output logic             ram_regce_out,
    output logic             ram_rst_out,
    input  logic [WIDTH-1:0] ram_dout_in
);
    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    localparam logic [AW:0]   LEN_MAX = (AW+1)'(DEPTH);
    localparam logic [AW:0]   LEN_ONE = (AW+1)'(1);
    localparam logic [AW-1:0] PTR_ONE = (AW)'(1);

    state_t                 state;
    state_t                 state_nxt;
    logic [AW:0]            len;
    logic [AW:0]            len_clamped;
    logic [AW-1:0]          ptr;
    logic [RAM_LATENCY-1:0] rd_vld_sr;
    logic [2:0]             inflight;
    logic [2:0]             fifo_cnt;
    logic                   accept;
    logic                   run_clear;
    logic                   ret_vld;
    logic                   push_vld;
    logic                   pop_vld;
    logic [WIDTH-1:0]       push_dat;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) state <= ST_INIT;
        else           state <= state_nxt;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            ST_INIT:  state_nxt = ST_RUN;
            ST_RUN:   if (clear_in) state_nxt = ST_FLUSH;
            ST_FLUSH: if (inflight == 3'd0) state_nxt = ST_INIT;
            default:  state_nxt = ST_INIT;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // Credit counts every read still travelling through the RAM so the FIFO
    // always has a slot reserved for each return.
    always_comb begin
        s_ready_out  = (state == ST_RUN) && (({1'b0, inflight} + {1'b0, fifo_cnt}) < 4'd4);
        accept       = s_valid_in && s_ready_out;
        run_clear    = (state == ST_RUN) && clear_in;
        // Returns arriving on the clear cycle or during FLUSH belong to the old stream.
        push_vld     = ret_vld && (state == ST_RUN) && !clear_in;
        ram_en_out   = accept;
        ram_we_out   = accept;
        ram_addr_out = accept ? ptr : '0;
        ram_din_out  = accept ? s_data_in : '0;
    end

    assign ram_regce_out = 1'b1;
    assign ram_rst_out   = 1'b0;

    always_comb begin
        if (delay_len_in == '0)          len_clamped = LEN_ONE;
        else if (delay_len_in > LEN_MAX) len_clamped = LEN_MAX;
        else                             len_clamped = delay_len_in;
    end

    // Pointer wraps at len, so the old word at ptr is exactly len accepts old.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            len <= LEN_ONE;
            ptr <= '0;
        end else begin
            if (state == ST_INIT) len <= len_clamped;
            if (run_clear)   ptr <= '0;
            else if (accept) ptr <= ({1'b0, ptr} == (len - LEN_ONE)) ? '0 : ptr + PTR_ONE;
        end
    end

    // Read-return tracker: one bit per RAM pipeline stage.
    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            rd_vld_sr <= '0;
        end else begin
            rd_vld_sr[0] <= accept;
            for (int i = 1; i < RAM_LATENCY; i++) rd_vld_sr[i] <= rd_vld_sr[i-1];
        end
    end

    assign ret_vld = rd_vld_sr[RAM_LATENCY-1];

    always_comb begin
        inflight = '0;
        for (int i = 0; i < RAM_LATENCY; i++) inflight = inflight + 3'(rd_vld_sr[i]);
    end

`ifdef DELAY_LINE_ZERO_FILL_EN
    // Fill counter saturates at len; accesses made before that read stale RAM.
    logic [AW:0]            fill;
    logic                   primed;
    logic [RAM_LATENCY-1:0] primed_sr;

    assign primed = (fill == len);

    always_ff @(posedge clk_in or negedge rst_in_n) begin
        if (!rst_in_n) begin
            fill      <= '0;
            primed_sr <= '0;
        end else begin
            if (run_clear)              fill <= '0;
            else if (accept && !primed) fill <= fill + LEN_ONE;
            primed_sr[0] <= primed;
            for (int i = 1; i < RAM_LATENCY; i++) primed_sr[i] <= primed_sr[i-1];
        end
    end

    assign push_dat = primed_sr[RAM_LATENCY-1] ? ram_dout_in : '0;
`else
    assign push_dat = ram_dout_in;
`endif

    assign pop_vld     = m_valid_out && m_ready_in;
    assign m_valid_out = (fifo_cnt != 3'd0);

    dl_fifo #(
        .W (WIDTH),
        .D (4)
    ) u_out_fifo (
        .clk      (clk_in),
        .rst_n    (rst_in_n),
        .clr      (run_clear),
        .push     (push_vld),
        .push_dat (push_dat),
        .pop      (pop_vld),
        .head_dat (m_data_out),
        .count    (fifo_cnt)
    );
endmodule
